// File: rtl/cube_scan.sv
// Layer-multiplexed LED-cube driver: snapshots the cell bitmap once per frame,
// shifts each layer's column bits to external latching drivers, then lights that layer.
module cube_scan #(
  parameter int SIZE    = 8,
  parameter int CLK_DIV = 4,
  parameter int DWELL   = 1024,
  parameter int BLANK   = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [SIZE**3-1:0]   Cells,
  input  logic                 Enable,
  output logic                 SerData,
  output logic                 SerClk,
  output logic                 Latch,
  output logic [SIZE-1:0]      Layers,
  output logic                 FrameStart
);

  localparam int unsigned N       = SIZE * SIZE;
  localparam int unsigned CELLS_W = N * SIZE;
  localparam int unsigned BIT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LAYER_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int          CNT_MAX_A = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int          CNT_MAX   = ((CNT_MAX_A > CLK_DIV) ? CNT_MAX_A : CLK_DIV) - 1;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_SHOW,
    ST_BLANK
  } state_e;

  state_e               state_q, state_d;
  logic [LAYER_W-1:0]   layer_q, layer_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 phase_q, phase_d;   // 0 = SerClk low half, 1 = high half
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CELLS_W-1:0]   frame_q, frame_d;

  logic                 ser_data_q, ser_data_d;
  logic                 ser_clk_q, ser_clk_d;
  logic                 latch_q, latch_d;
  logic [SIZE-1:0]      layers_q, layers_d;
  logic                 frame_start_q, frame_start_d;

  logic [N-1:0]         layer_bits;
  int unsigned          shamt;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Enable) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        // Cells is sampled only here, so a displayed frame never tears.
        if (layer_q == '0) frame_d = Cells;
        bit_d   = BIT_W'(N - 1);
        phase_d = 1'b0;
        cnt_d   = CNT_W'(CLK_DIV - 1);
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = CNT_W'(CLK_DIV - 1);
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q - BIT_W'(1);
          end
        end
      end

      ST_LATCH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = CNT_W'(DWELL - 1);
          state_d = ST_SHOW;
        end
      end

      ST_SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = CNT_W'(BLANK - 1);
          state_d = ST_BLANK;
        end
      end

      ST_BLANK: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = '0;
          layer_d = (layer_q == LAYER_W'(SIZE - 1)) ? '0 : layer_q + LAYER_W'(1);
          state_d = Enable ? ST_LOAD : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the output flops line up with the state flops.
  always_comb begin
    shamt         = N * 32'(layer_d);
    layer_bits    = N'(frame_d >> shamt);
    ser_data_d    = (state_d == ST_SHIFT) && layer_bits[bit_d];
    ser_clk_d     = (state_d == ST_SHIFT) && phase_d;
    latch_d       = (state_d == ST_LATCH);
    layers_d      = (state_d == ST_SHOW) ? (SIZE'(1) << layer_d) : '0;
    frame_start_d = (state_d == ST_LOAD) && (layer_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the frame buffer is cleared on reset too, so nothing from before reset can reach the pins.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_IDLE;
      layer_q       <= '0;
      bit_q         <= '0;
      phase_q       <= 1'b0;
      cnt_q         <= '0;
      frame_q       <= '0;
      ser_data_q    <= 1'b0;
      ser_clk_q     <= 1'b0;
      latch_q       <= 1'b0;
      layers_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      bit_q         <= bit_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      ser_data_q    <= ser_data_d;
      ser_clk_q     <= ser_clk_d;
      latch_q       <= latch_d;
      layers_q      <= layers_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign SerData    = ser_data_q;
  assign SerClk     = ser_clk_q;
  assign Latch      = latch_q;
  assign Layers     = layers_q;
  assign FrameStart = frame_start_q;

endmodule

// File: doc/cube_scan.md
Name: cube_scan

Overview:
- Parametrised LED-cube driver; successor to the fixed 8x8x8 output stage.
- Displays a SIZE x SIZE x SIZE cell bitmap by multiplexing one layer at a time.
- For each layer: shifts the layer's SIZE*SIZE column bits out serially to external latching column drivers, latches them, then enables that layer's transistor for a fixed dwell.
- Sits between the simulation core (Cells) and the board pins.

Parameters:
- SIZE, 8: cube edge length; Cells width is SIZE**3; layer count is SIZE.
- CLK_DIV, 4: Clk cycles per SerClk half-period; also Latch pulse length; must be >=1.
- DWELL, 1024: Clk cycles a layer is lit; must be >=1.
- BLANK, 16: Clk cycles all layers off after each dwell (ghosting guard); must be >=1.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Cells  input  SIZE**3  cell bitmap; bit index z*SIZE*SIZE + y*SIZE + x; z is the layer.
- Enable  input  1  1 = scan continuously; 0 = stop after the current layer.
- SerData  output  1  serial column data to the driver chain.
- SerClk  output  1  shift clock; drivers sample SerData on its rising edge.
- Latch  output  1  transfers the shifted word to the driver outputs.
- Layers  output  SIZE  one-hot layer enable; all-zero except in SHOW.
- FrameStart  output  1  one-cycle pulse when the layer-0 snapshot is taken.

Behaviour:
- Rst_n=0, asynchronous: state=IDLE, layer index=0, counters=0, frame buffer=0; all outputs 0 immediately.
- Reset mid-operation aborts the shift, latch and dwell with no completion; after release, scanning restarts at layer 0.
- All outputs are registered. Counter widths use $clog2 of their maximum value.
- IDLE:
  - All outputs 0.
  - Enable=1 sampled -> LOAD.
- LOAD, 1 cycle:
  - If layer==0: copy Cells into the internal frame buffer and assert FrameStart for this cycle.
  - Cells is never read outside this cycle, so a frame never tears.
  - Set bit counter = SIZE*SIZE-1 -> SHIFT.
- SHIFT:
  - Bits of the current layer go out from index SIZE*SIZE-1 down to 0.
  - Each bit: SerData updates at the start of the SerClk low phase; SerClk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - SerData is stable for the whole high phase.
  - After the high phase of bit 0 -> LATCH, with SerClk=0.
- LATCH: Latch=1 for CLK_DIV cycles, SerClk=0 -> SHOW.
- SHOW: Layers = 1<<layer for DWELL cycles -> BLANK.
- BLANK:
  - Layers=0 for BLANK cycles.
  - On the last cycle, layer increments, wrapping SIZE-1 -> 0.
  - Then -> LOAD if Enable=1, else IDLE.
- Enable=0 mid-layer: the current layer finishes through BLANK, then IDLE. It is not sampled anywhere else.
- Layers is 0 throughout LOAD, SHIFT, LATCH and BLANK, so at most one layer is ever lit.
- SerData is don't-care but held at 0 outside SHIFT.
- Per-layer period = 1 + 2*CLK_DIV*SIZE*SIZE + CLK_DIV + DWELL + BLANK Clk cycles.
  - Defaults: 1557 per layer; FrameStart period 12456.

Test Plan:
- Rst_n=0 with random Cells -> all outputs 0. Release with Enable=0 for 100 cycles -> outputs stay 0, no SerClk edge.
- SIZE=2, CLK_DIV=1, DWELL=4, BLANK=2, Cells=8'b1010_0110, Enable=1:
  - Layer 0: SerData sampled at SerClk rises = 0,1,1,0; Latch high 1 cycle; Layers=2'b01 for 4 cycles.
  - Layer 1: bits 1,0,1,0, then Layers=2'b10.
  - FrameStart every 32 cycles.
- Same setup; change Cells to 8'hFF during layer 1 SHIFT -> layer 1 still shifts 1,0,1,0. Next frame shifts all ones after FrameStart.
- Deassert Enable during layer 0 SHIFT -> layer 0 completes its 4-cycle SHOW and 2-cycle BLANK, then IDLE. Layers=0 and no further SerClk or Latch activity.
- Assert Rst_n=0 during layer 1 SHOW -> Layers=0 before the next Clk edge. Release with Enable=1 -> next shift is layer 0, with FrameStart in the LOAD cycle.
- Default parameters, Cells all ones -> exactly 64 SerClk rises per layer. Layers walks 01,02,04..80 then wraps; FrameStart period 12456 cycles.
